// File: rtl/rf_wr_arb.sv
// Register-file write arbiter: two buffered writeback requesters share one write port.
// Define RF_WR_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 1.
module rf_wr_arb #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [2:0]  req0_regsel,
    input  logic [15:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [2:0]  req1_regsel,
    input  logic [15:0] req1_data,
    output logic        req1_ready,
    output logic        write,
    output logic [2:0]  writeregsel,
    output logic [15:0] writedata,
    output logic        grant,
    output logic [7:0]  pending
);

    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [1:0]        in_valid;
    logic [1:0]        in_ready;
    logic [1:0]        nonempty;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic [1:0][2:0]   in_regsel;
    logic [1:0][15:0]  in_data;
    logic [1:0][2:0]   head_regsel;
    logic [1:0][15:0]  head_data;
    logic [1:0][7:0]   fifo_pending;
    logic              grant_sel;

    assign in_valid     = {req1_valid, req0_valid};
    assign in_regsel[0] = req0_regsel;
    assign in_regsel[1] = req1_regsel;
    assign in_data[0]   = req0_data;
    assign in_data[1]   = req1_data;
    assign req0_ready   = in_ready[0];
    assign req1_ready   = in_ready[1];
    assign push         = in_valid & in_ready;

    genvar gi, gj;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [2:0]    regsel_mem [DEPTH];
            logic [15:0]   data_mem   [DEPTH];
            logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
            logic [PW:0]   count_reg, count_next;
            logic [PW-1:0] slot_off [DEPTH];
            logic [7:0]    slot_pend;

            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    regsel_mem[wr_ptr_reg] <= in_regsel[gi];
                    data_mem[wr_ptr_reg]   <= in_data[gi];
                end
            end

            always_comb begin
                count_next = count_reg;
                case ({push[gi], pop[gi]})
                    2'b10:   count_next = count_reg + (PW+1)'(1);
                    2'b01:   count_next = count_reg - (PW+1)'(1);
                    default: count_next = count_reg;
                endcase
            end

            // Pointers are exactly PW bits wide, so increment wraps modulo DEPTH.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    count_reg <= count_next;
                end
            end

            assign in_ready[gi]    = (count_reg != FULL_CNT);
            assign nonempty[gi]    = (count_reg != '0);
            assign head_regsel[gi] = regsel_mem[rd_ptr_reg];
            assign head_data[gi]   = data_mem[rd_ptr_reg];

            // A slot is occupied when its distance from the read pointer is below the count.
            for (gj = 0; gj < DEPTH; gj++) begin : g_slot
                assign slot_off[gj] = PW'(gj) - rd_ptr_reg;
            end

            always_comb begin
                slot_pend = '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if ({1'b0, slot_off[j]} < count_reg)
                        slot_pend[regsel_mem[j]] = 1'b1;
                end
            end

            assign fifo_pending[gi] = slot_pend;
        end
    endgenerate

`ifdef RF_WR_ARB_RR_EN
    logic prio_reg;

    // Only contested cycles hand preference to the other requester.
    always_ff @(posedge clk) begin
        if (rst)
            prio_reg <= 1'b0;
        else if (&nonempty)
            prio_reg <= ~prio_reg;
    end
`endif

    always_comb begin
        grant_sel = 1'b0;
        if (&nonempty) begin
`ifdef RF_WR_ARB_RR_EN
            grant_sel = prio_reg;
`else
            grant_sel = 1'b1;
`endif
        end else if (nonempty[1]) begin
            grant_sel = 1'b1;
        end
    end

    assign write       = |nonempty;
    assign pop         = write ? (grant_sel ? 2'b10 : 2'b01) : 2'b00;
    assign grant       = write & grant_sel;
    assign writeregsel = head_regsel[grant_sel];
    assign writedata   = head_data[grant_sel];
    assign pending     = fifo_pending[0] | fifo_pending[1];

endmodule

// File: tb/tb_rf_wr_arb.sv
// Bench for rf_wr_arb: DEPTH=2 and DEPTH=4 instances share stimulus; a queue model
// checks every cycle, directed literal checks pin the model to known scenarios.
module tb_rf_wr_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [2:0]  s0 = '0, s1 = '0;
    logic [15:0] d0 = '0, d1 = '0;

    logic        rdy0 [2];
    logic        rdy1 [2];
    logic        w    [2];
    logic        g    [2];
    logic [2:0]  wsel [2];
    logic [15:0] wdat [2];
    logic [7:0]  pend [2];

    int n_checks = 0;
    int n_fail   = 0;

    rf_wr_arb #(.DEPTH(2)) dut2 (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_regsel(s0), .req0_data(d0), .req0_ready(rdy0[0]),
        .req1_valid(v1), .req1_regsel(s1), .req1_data(d1), .req1_ready(rdy1[0]),
        .write(w[0]), .writeregsel(wsel[0]), .writedata(wdat[0]),
        .grant(g[0]), .pending(pend[0])
    );

    rf_wr_arb #(.DEPTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_regsel(s0), .req0_data(d0), .req0_ready(rdy0[1]),
        .req1_valid(v1), .req1_regsel(s1), .req1_data(d1), .req1_ready(rdy1[1]),
        .write(w[1]), .writeregsel(wsel[1]), .writedata(wdat[1]),
        .grant(g[1]), .pending(pend[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: queue per (instance, requester), index = inst*2 + requester; entry = {regsel, data}.
    logic [18:0] mq [4][$];
    bit          mprio [2];

    always @(negedge clk) begin
        int          dep, i0, i1, gi;
        bit          e_w, e_g, both;
        bit          e_r [2];
        logic [7:0]  e_p;
        logic [18:0] head;
        for (int k = 0; k < 2; k++) begin
            dep  = (k == 0) ? 2 : 4;
            i0   = k * 2;
            i1   = k * 2 + 1;
            e_p  = '0;
            foreach (mq[i0][n]) e_p[mq[i0][n][18:16]] = 1'b1;
            foreach (mq[i1][n]) e_p[mq[i1][n][18:16]] = 1'b1;
            e_r[0] = mq[i0].size() < dep;
            e_r[1] = mq[i1].size() < dep;
            both   = (mq[i0].size() != 0) && (mq[i1].size() != 0);
            e_w    = (mq[i0].size() != 0) || (mq[i1].size() != 0);
`ifdef RF_WR_ARB_RR_EN
            e_g = both ? mprio[k] : (mq[i1].size() != 0);
`else
            e_g = both ? 1'b1 : (mq[i1].size() != 0);
`endif
            chk($sformatf("d%0d_ready0", dep), 32'(rdy0[k]), 32'(e_r[0]));
            chk($sformatf("d%0d_ready1", dep), 32'(rdy1[k]), 32'(e_r[1]));
            chk($sformatf("d%0d_write", dep), 32'(w[k]), 32'(e_w));
            chk($sformatf("d%0d_pending", dep), 32'(pend[k]), 32'(e_p));
            chk($sformatf("d%0d_grant", dep), 32'(g[k]), 32'(e_w & e_g));
            gi = k * 2 + int'(e_g);
            if (e_w) begin
                head = mq[gi][0];
                chk($sformatf("d%0d_writeregsel", dep), 32'(wsel[k]), 32'(head[18:16]));
                chk($sformatf("d%0d_writedata", dep), 32'(wdat[k]), 32'(head[15:0]));
            end
            if (rst) begin
                mq[i0].delete();
                mq[i1].delete();
                mprio[k] = 1'b0;
            end else begin
                if (e_w) begin
                    void'(mq[gi].pop_front());
`ifdef RF_WR_ARB_RR_EN
                    if (both) mprio[k] = !mprio[k];
`endif
                end
                if (v0 && e_r[0]) mq[i0].push_back({s0, d0});
                if (v1 && e_r[1]) mq[i1].push_back({s1, d1});
            end
        end
    end

    task automatic step(input bit a0, input logic [2:0] as0, input logic [15:0] ad0,
                        input bit a1, input logic [2:0] as1, input logic [15:0] ad1);
        v0 = a0; s0 = as0; d0 = ad0;
        v1 = a1; s1 = as1; d1 = ad1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    endtask

    initial begin
        // Reset state and the cycle after release
        rst = 1'b1;
        idle();
        idle();
        chk("rst_write", 32'(w[0]), 32'h0);
        chk("rst_grant", 32'(g[0]), 32'h0);
        chk("rst_pending", 32'(pend[0]), 32'h0);
        chk("rst_ready0", 32'(rdy0[0]), 32'h1);
        chk("rst_ready1", 32'(rdy1[0]), 32'h1);
        rst = 1'b0;
        idle();
        chk("post_rst_write", 32'(w[0]), 32'h0);

        // Single write to r3
        step(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0);
        chk("r3_write", 32'(w[0]), 32'h1);
        chk("r3_sel", 32'(wsel[0]), 32'h3);
        chk("r3_data", 32'(wdat[0]), 32'h1234);
        chk("r3_grant", 32'(g[0]), 32'h0);
        chk("r3_pending", 32'(pend[0]), 32'h08);
        idle();
        chk("r3_pending_clr", 32'(pend[0]), 32'h00);
        chk("r3_write_clr", 32'(w[0]), 32'h0);

        // Requester 0 streaming without contest
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 3'(i), 16'h0100 + 16'(i), 1'b0, 3'd0, 16'h0);
            chk("stream_ready0", 32'(rdy0[0]), 32'h1);
            chk("stream_write", 32'(w[0]), 32'h1);
            chk("stream_data", 32'(wdat[0]), 32'h0100 + 32'(i));
        end
        idle();
        chk("stream_drained", 32'(w[0]), 32'h0);

        // Same register from both requesters in one cycle
        step(1'b1, 3'd5, 16'hAAAA, 1'b1, 3'd5, 16'h5555);
`ifdef RF_WR_ARB_RR_EN
        chk("r5_first", 32'(wdat[0]), 32'hAAAA);
`else
        chk("r5_first", 32'(wdat[0]), 32'h5555);
`endif
        chk("r5_pend_a", 32'(pend[0][5]), 32'h1);
        idle();
`ifdef RF_WR_ARB_RR_EN
        chk("r5_second", 32'(wdat[0]), 32'h5555);
`else
        chk("r5_second", 32'(wdat[0]), 32'hAAAA);
`endif
        chk("r5_pend_b", 32'(pend[0][5]), 32'h1);
        idle();
        chk("r5_pend_clr", 32'(pend[0]), 32'h0);

        // Both push every cycle, from a fresh reset
        rst = 1'b1;
        idle();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 3'(k), 16'h3000 + 16'(k), 1'b1, 3'(k + 1), 16'h3100 + 16'(k));
`ifdef RF_WR_ARB_RR_EN
            chk("contest_grant", 32'(g[0]), 32'(k % 2));
`else
            chk("contest_grant", 32'(g[0]), 32'h1);
            if (k >= 1) chk("contest_ready0", 32'(rdy0[0]), 32'h0);
`endif
        end

        // Reset with buffers loaded and pushes present
        rst = 1'b1;
        step(1'b1, 3'd7, 16'hDEAD, 1'b1, 3'd7, 16'hBEEF);
        for (int k = 0; k < 2; k++) begin
            chk("ld_rst_write", 32'(w[k]), 32'h0);
            chk("ld_rst_pending", 32'(pend[k]), 32'h0);
            chk("ld_rst_ready0", 32'(rdy0[k]), 32'h1);
            chk("ld_rst_ready1", 32'(rdy1[k]), 32'h1);
        end
        rst = 1'b0;
        idle();
        chk("ld_post_write", 32'(w[1]), 32'h0);
        chk("ld_post_pending", 32'(pend[1]), 32'h0);

        // Interleaved pushes and stalls to wrap the DEPTH=4 pointers
        for (int i = 0; i < 14; i++) begin
            step((i % 3) != 2, 3'(i), 16'h4000 + 16'(i),
                 (i % 2) == 0, 3'(7 - (i % 8)), 16'h5000 + 16'(i));
        end
        for (int i = 0; i < 12; i++) idle();
        chk("wrap_drained_write", 32'(w[1]), 32'h0);
        chk("wrap_drained_pending", 32'(pend[1]), 32'h0);

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
